// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared widths, FSM encoding and address field helpers for the cache-to-memory interface.
package mem_if_pkg;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 16;
    localparam int NUM_CORES = 2;
    localparam int IDX_W     = 5;
    localparam int TAG_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WB   = 2'b01,
        READ = 2'b10,
        DONE = 2'b11
    } state_e;

    function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:IDX_W];
    endfunction
endpackage

// File: rtl/memory_array_512x16.sv
// memory_array_512x16: backing store with synchronous write and combinational read.
module memory_array_512x16
    import mem_if_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mem_responder_2port_512x16.sv
// mem_responder_2port_512x16: round-robin memory responder for two L1 caches; a write-back and
// the read of the same miss are served back-to-back without re-arbitration.
module mem_responder_2port_512x16 #(
    parameter int MEM_LATENCY = 3,
    parameter int ADDR_W      = mem_if_pkg::ADDR_W,
    parameter int DATA_W      = mem_if_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          read_req_i,
    input  logic [2*ADDR_W-1:0] ask_mem_address_i,
    input  logic [1:0]          write_back_i,
    input  logic [2*ADDR_W-1:0] wb_address_i,
    input  logic [2*DATA_W-1:0] wb_data_i,
    output logic [2*DATA_W-1:0] mem_data_delivery_o,
    output logic [1:0]          data_ready_o,
    output logic [1:0]          wb_ack_o,
    output logic                busy_o
);
    import mem_if_pkg::*;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_e              state_q, state_d;
    logic                last_q, last_d, gnt_q, gnt_d, rd_q, rd_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d, rdata;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          dr_q, dr_d, ack_q, ack_d, pend;
    logic [2*DATA_W-1:0] mdd_q, mdd_d;
    logic                g, we;

    assign pend = read_req_i | write_back_i;
    assign g    = &pend ? ~last_q : pend[1];
    // rst on the WB closing edge must abort the commit
    assign we   = (state_q == WB) && !rst;

    memory_array_512x16 u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wb_addr_q),
        .wdata_i (wb_data_q),
        .raddr_i (rd_addr_q),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        rd_d      = rd_q;
        rd_addr_d = rd_addr_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        cnt_d     = cnt_q;
        dr_d      = '0;
        ack_d     = '0;
        mdd_d     = mdd_q;
        case (state_q)
            IDLE: if (|pend) begin
                gnt_d     = g;
                last_d    = g;
                rd_d      = read_req_i[g];
                rd_addr_d = g ? ask_mem_address_i[2*ADDR_W-1:ADDR_W] : ask_mem_address_i[ADDR_W-1:0];
                wb_addr_d = g ? wb_address_i[2*ADDR_W-1:ADDR_W] : wb_address_i[ADDR_W-1:0];
                wb_data_d = g ? wb_data_i[2*DATA_W-1:DATA_W] : wb_data_i[DATA_W-1:0];
                state_d   = write_back_i[g] ? WB : READ;
                cnt_d     = CNT_INIT;
            end
            WB: begin
                ack_d[gnt_q] = 1'b1;
                state_d      = rd_q ? READ : DONE;
                cnt_d        = CNT_INIT;
            end
            READ: if (cnt_q == 4'd0) begin
                dr_d[gnt_q] = 1'b1;
                if (gnt_q) mdd_d[2*DATA_W-1:DATA_W] = rdata;
                else mdd_d[DATA_W-1:0] = rdata;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            rd_q      <= 1'b0;
            rd_addr_q <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            cnt_q     <= '0;
            dr_q      <= '0;
            ack_q     <= '0;
            mdd_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            rd_q      <= rd_d;
            rd_addr_q <= rd_addr_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            cnt_q     <= cnt_d;
            dr_q      <= dr_d;
            ack_q     <= ack_d;
            mdd_q     <= mdd_d;
        end
    end

    assign mem_data_delivery_o = mdd_q;
    assign data_ready_o        = dr_q;
    assign wb_ack_o            = ack_q;
    assign busy_o              = state_q != IDLE;
endmodule
